// File: rtl/hgc_vgaport_pal.sv
// ---------------------------------------------------------------------------
// hgc_vgaport_pal
//
// Palette-based VGA colour port for the Hercules/MDA/CGA video paths.
// Each pixel's colour index is looked up in a host-writable palette held in
// flops. The palette has 2**IDX_BITS entries of {r,g,b}. The result is
// driven as registered R/G/B to the resistor DAC, and the syncs are delayed
// by the same two clocks so they stay aligned with the colour.
//
// Optional feature macro: HGC_VGA_SCANLINE_EN
//   When defined, a line-parity flop dims every other line to half
//   intensity (each channel shifted right by one). The latency is the same
//   whether or not the macro is defined.
//
// Ports
//   clk        pixel clock, all logic on posedge
//   reset_n    asynchronous active-low reset
//   pix        colour index for the current pixel
//   de         display enable (0 = blanking, forces colour to 0)
//   hsync_in   horizontal sync in, active high
//   vsync_in   vertical sync in, active high
//   pal_we     palette write strobe (single cycle, back-to-back allowed)
//   pal_addr   palette entry to write
//   pal_wdata  {r,g,b} palette write data
//   red/green/blue  registered DAC drive
//   hsync/vsync     syncs delayed to match the colour pipeline
// ---------------------------------------------------------------------------
module hgc_vgaport_pal #(
  parameter int IDX_BITS = 2,
  parameter int R_BITS   = 6,
  parameter int G_BITS   = 7,
  parameter int B_BITS   = 6
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [IDX_BITS-1:0]              pix,
  input  logic                             de,
  input  logic                             hsync_in,
  input  logic                             vsync_in,
  input  logic                             pal_we,
  input  logic [IDX_BITS-1:0]              pal_addr,
  input  logic [R_BITS+G_BITS+B_BITS-1:0]  pal_wdata,
  output logic [R_BITS-1:0]                red,
  output logic [G_BITS-1:0]                green,
  output logic [B_BITS-1:0]                blue,
  output logic                             hsync,
  output logic                             vsync
);

  localparam int N  = 1 << IDX_BITS;
  localparam int PW = R_BITS + G_BITS + B_BITS;

  // Grey-ramp reset value of entry k: each channel = floor(k*(2**W-1)/(N-1)).
  function automatic logic [PW-1:0] ramp_entry(input int k);
    int rv;
    int gv;
    int bv;
    rv = (k * ((1 << R_BITS) - 1)) / (N - 1);
    gv = (k * ((1 << G_BITS) - 1)) / (N - 1);
    bv = (k * ((1 << B_BITS) - 1)) / (N - 1);
    return {rv[R_BITS-1:0], gv[G_BITS-1:0], bv[B_BITS-1:0]};
  endfunction

  logic [PW-1:0]       pal_r [N];
  logic [IDX_BITS-1:0] s1_pix_r;
  logic                s1_de_r;
  logic                s1_hs_r;
  logic                s1_vs_r;

  logic [PW-1:0]       entry_s;
  logic [R_BITS-1:0]   r_s;
  logic [G_BITS-1:0]   g_s;
  logic [B_BITS-1:0]   b_s;

  // Palette storage: ramp on reset, single-entry host write per edge.
  // The S2 lookup on the same edge as a write samples the old contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        pal_r[k] <= ramp_entry(k);
      end
    end else if (pal_we) begin
      pal_r[pal_addr] <= pal_wdata;
    end else begin
      pal_r[pal_addr] <= pal_r[pal_addr];
    end
  end

  // Stage 1: capture the pixel index, enable and syncs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_pix_r <= {IDX_BITS{1'b0}};
      s1_de_r  <= 1'b0;
      s1_hs_r  <= 1'b0;
      s1_vs_r  <= 1'b0;
    end else begin
      s1_pix_r <= pix;
      s1_de_r  <= de;
      s1_hs_r  <= hsync_in;
      s1_vs_r  <= vsync_in;
    end
  end

`ifdef HGC_VGA_SCANLINE_EN
  logic parity_r;
  logic hs_rise_s;
  logic vs_rise_s;

  // Sync edges are detected against the stage-1 copies.
  assign hs_rise_s = hsync_in & ~s1_hs_r;
  assign vs_rise_s = vsync_in & ~s1_vs_r;

  // Line parity: toggles per line, and a frame start clears it (the clear wins).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_r <= 1'b0;
    end else if (vs_rise_s) begin
      parity_r <= 1'b0;
    end else if (hs_rise_s) begin
      parity_r <= ~parity_r;
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  // Colour lookup for stage 2, with optional dim and blanking.
  always_comb begin
    entry_s = pal_r[s1_pix_r];
    r_s     = entry_s[PW-1 -: R_BITS];
    g_s     = entry_s[G_BITS+B_BITS-1 -: G_BITS];
    b_s     = entry_s[B_BITS-1:0];
`ifdef HGC_VGA_SCANLINE_EN
    if (parity_r) begin
      r_s = r_s >> 1;
      g_s = g_s >> 1;
      b_s = b_s >> 1;
    end else begin
      r_s = r_s;
      g_s = g_s;
      b_s = b_s;
    end
`endif
    if (!s1_de_r) begin
      r_s = {R_BITS{1'b0}};
      g_s = {G_BITS{1'b0}};
      b_s = {B_BITS{1'b0}};
    end else begin
      r_s = r_s;
      g_s = g_s;
      b_s = b_s;
    end
  end

  // Stage 2: registered DAC drive and the delayed syncs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red   <= {R_BITS{1'b0}};
      green <= {G_BITS{1'b0}};
      blue  <= {B_BITS{1'b0}};
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      red   <= r_s;
      green <= g_s;
      blue  <= b_s;
      hsync <= s1_hs_r;
      vsync <= s1_vs_r;
    end
  end

endmodule

// File: tb/tb_hgc_vgaport_pal.sv
// ---------------------------------------------------------------------------
// tb_hgc_vgaport_pal
//
// Bench for hgc_vgaport_pal with the default parameters. A reference
// palette and a two-entry expected-output pipe are kept in the bench. Every
// cycle is compared against them at the falling edge. Hand-computed literal
// checks pin the reset ramp, the latency, blanking, writes, the write/read
// collision and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_hgc_vgaport_pal;

  localparam int IB = 2;
  localparam int RB = 6;
  localparam int GB = 7;
  localparam int BB = 6;
  localparam int PW = RB + GB + BB;
  localparam int N  = 1 << IB;

  logic          clk;
  logic          reset_n;
  logic [IB-1:0] pix;
  logic          de;
  logic          hsync_in;
  logic          vsync_in;
  logic          pal_we;
  logic [IB-1:0] pal_addr;
  logic [PW-1:0] pal_wdata;
  logic [RB-1:0] red;
  logic [GB-1:0] green;
  logic [BB-1:0] blue;
  logic          hsync;
  logic          vsync;

  hgc_vgaport_pal #(.IDX_BITS(IB), .R_BITS(RB), .G_BITS(GB), .B_BITS(BB)) dut (
    .clk(clk), .reset_n(reset_n), .pix(pix), .de(de),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: palette contents plus the expected output for the edge
  // just driven (pipe0) and for the edge before it (pipe1).
  logic [PW-1:0]   mpal [N];
  logic [PW+1:0]   pipe0;
  logic [PW+1:0]   pipe1;
  logic            m_par;
  logic            m_prev_hs;
  logic            m_prev_vs;

  function automatic logic [PW-1:0] grey(input int k);
    int rv;
    int gv;
    int bv;
    rv = k * 63 / (N - 1);
    gv = k * 127 / (N - 1);
    bv = k * 63 / (N - 1);
    return {rv[RB-1:0], gv[GB-1:0], bv[BB-1:0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) mpal[k] = grey(k);
    pipe0     = '0;
    pipe1     = '0;
    m_par     = 1'b0;
    m_prev_hs = 1'b0;
    m_prev_vs = 1'b0;
  endtask

  task automatic check(input string name, input logic [PW+1:0] got, input logic [PW+1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got r/g/b/hs/vs=%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
               name, got[PW+1 -: RB], got[GB+BB+1 -: GB], got[BB+1 -: BB], got[1], got[0],
               exp[PW+1 -: RB], exp[GB+BB+1 -: GB], exp[BB+1 -: BB], exp[1], exp[0]);
    end
  endtask

  function automatic logic [PW+1:0] outs();
    return {red, green, blue, hsync, vsync};
  endfunction

  // One pixel clock: check the outputs against the model, then drive the
  // next inputs and predict the output they will produce two edges later.
  task automatic cycle(input logic [IB-1:0] p, input logic d, input logic hs, input logic vs,
                       input logic we, input logic [IB-1:0] a, input logic [PW-1:0] wd);
    logic [PW-1:0] c;
    @(negedge clk);
    check("model", outs(), pipe1);
    pix = p; de = d; hsync_in = hs; vsync_in = vs;
    pal_we = we; pal_addr = a; pal_wdata = wd;
    // The lookup happens one edge after this write, so it sees the new value
    // only if the write targeted an earlier edge; this edge's write is applied
    // first because the lookup for these inputs happens at the next edge.
    if (we) mpal[a] = wd;
    c = mpal[p];
`ifdef HGC_VGA_SCANLINE_EN
    if (vs && !m_prev_vs) m_par = 1'b0;
    else if (hs && !m_prev_hs) m_par = ~m_par;
    m_prev_hs = hs;
    m_prev_vs = vs;
    if (m_par) c = {c[PW-1 -: RB] >> 1, c[GB+BB-1 -: GB] >> 1, c[BB-1:0] >> 1};
`endif
    if (!d) c = '0;
    pipe1 = pipe0;
    pipe0 = {c, hs, vs};
  endtask

  task automatic idle();
    cycle('0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset between edges: outputs must clear with no clock.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    pix = '0; de = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    pal_we = 1'b0; pal_addr = '0; pal_wdata = '0;
    #1;
    check("async_reset", outs(), '0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    pix = '0; de = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    pal_we = 1'b0; pal_addr = '0; pal_wdata = '0;
    model_reset();
    #1;
    check("reset_state", outs(), '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset ramp readout, 2-clock latency.
    cycle(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    check("ramp0", outs(), {6'd0, 7'd0, 6'd0, 1'b0, 1'b0});
    cycle(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    check("ramp1", outs(), {6'd21, 7'd42, 6'd21, 1'b0, 1'b0});
    idle();
    check("ramp2", outs(), {6'd42, 7'd84, 6'd42, 1'b0, 1'b0});
    idle();
    check("ramp3", outs(), {6'd63, 7'd127, 6'd63, 1'b0, 1'b0});

    // Latency, blanking and sync delay.
    cycle(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    cycle(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle();
    check("latency_hsync", outs(), {6'd63, 7'd127, 6'd63, 1'b1, 1'b0});
    idle();
    check("blanking", outs(), {6'd0, 7'd0, 6'd0, 1'b0, 1'b0});

    // Palette write then lookup.
    cycle(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, {6'd16, 7'd24, 6'd0});
    cycle(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    idle();
    idle();
    check("pal_write", outs(), {6'd16, 7'd24, 6'd0, 1'b0, 1'b0});

    // Write on the same edge as the S2 lookup of that entry.
    cycle(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle(2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, {6'd48, 7'd42, 6'd0});
    idle();
    check("collide_old", outs(), {6'd42, 7'd84, 6'd42, 1'b0, 1'b0});
    idle();
    check("collide_new", outs(), {6'd48, 7'd42, 6'd0, 1'b0, 1'b0});

    // Mid-stream reset restores the ramp.
    cycle(2'd3, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
    cycle(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    mid_reset();
    cycle(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    idle();
    idle();
    check("ramp_after_reset", outs(), {6'd21, 7'd42, 6'd21, 1'b0, 1'b0});

    // Randomised traffic against the model, with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) mid_reset();
      cycle(IB'($urandom_range(N - 1)), ($urandom_range(3) != 0),
            1'($urandom), 1'($urandom),
            ($urandom_range(3) == 0), IB'($urandom_range(N - 1)), PW'($urandom));
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
